branch_ctrl_unit: RTL
=====================

BRANCH_CTRL_UNIT -- requirements
Module: branch_ctrl_unit

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit predictor counters (power of two, 4..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of the mispredict counter.
REQ-003 SHALL have port CLK  in  1  single clock, all state rising-edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_pc  in  32  PC of the instruction in IF.
REQ-006 SHALL have port pred_taken  out  1  taken prediction for if_pc, combinational.
REQ-007 SHALL have port ex_valid  in  1  EX holds a valid conditional branch this cycle.
REQ-008 SHALL have port ex_pc  in  32  PC of the EX branch.
REQ-009 SHALL have port ex_pred_taken  in  1  prediction carried down the pipeline with that branch.
REQ-010 SHALL have port ex_branch_out  in  1  resolved outcome from the EX branch comparator.
REQ-011 SHALL have port ex_target  in  32  computed branch target.
REQ-012 SHALL have port stall  in  1  pipeline freeze.
REQ-013 SHALL have port redirect  out  1  PC-override pulse to IF.
REQ-014 SHALL have port redirect_pc  out  32  corrected fetch address.
REQ-015 SHALL have port flush  out  1  squash IF/ID and ID/EX registers.
REQ-016 SHALL have port mispredict_count  out  CNT_W  saturating mispredict count.

Function
REQ-017 SHALL index the BHT with pc[log2(BHT_ENTRIES)+1:2]; pred_taken = counter[1] of the entry indexed by if_pc.
REQ-018 SHALL define "resolve" as ex_valid=1, stall=0, state=IDLE; no other cycle counts as a resolution.
REQ-019 On resolve, SHALL update the ex_pc entry at the clock edge: taken -> increment saturating at 11; not taken -> decrement saturating at 00.
REQ-020 Read/update to the same index in one cycle SHALL return the pre-update value on pred_taken.
REQ-021 SHALL define "mispredict" as resolve with ex_branch_out != ex_pred_taken.
REQ-022 SHALL implement FSM IDLE -> REDIRECT -> FLUSH -> IDLE; IDLE->REDIRECT only on mispredict.
REQ-023 In REDIRECT, SHALL drive redirect=1, flush=1, redirect_pc = ex_target if the mispredicted branch was taken, else ex_pc+4 (mod 2^32), latched at the mispredict edge.
REQ-024 In FLUSH, SHALL drive redirect=0, flush=1; in IDLE, redirect=0, flush=0.
REQ-025 When stall=1, the FSM SHALL hold state and outputs; BHT and counter SHALL not change.
REQ-026 ex_valid in REDIRECT or FLUSH SHALL be ignored (wrong-path): no BHT update, no count.
REQ-027 mispredict_count SHALL increment by 1 per mispredict and saturate at all-ones.
REQ-028 redirect_pc SHALL hold its last value when redirect=0.
REQ-029 Latency SHALL be: mispredict at edge N -> redirect/flush high in cycle N+1, flush-only N+2, IDLE N+3.

Reset
REQ-030 While RESET=1, independent of CLK: state=IDLE, redirect=0, flush=0, redirect_pc=0, mispredict_count=0, every BHT entry=01 (weakly not taken).
REQ-031 Reset asserted in REDIRECT or FLUSH SHALL abort the sequence immediately; the first edge after release SHALL evaluate from IDLE.

Verification
REQ-032 After reset, if_pc=0x100 -> pred_taken=0; ex_valid=1, ex_pc=0x100, ex_branch_out=1, ex_pred_taken=0, ex_target=0x80 -> next cycle redirect=1, flush=1, redirect_pc=0x80; then flush only; then idle; mispredict_count=1; pred_taken for 0x100 now 1.
REQ-033 Resolve taken three times at ex_pc=0x40 with correct predictions -> counter saturates at 11, no redirect/flush, count unchanged; one not-taken resolve -> entry 10, pred_taken still 1, mispredict flow with redirect_pc=0x44.
REQ-034 Mispredict, then stall=1 for 3 cycles in REDIRECT -> redirect/flush held 3 extra cycles, then normal FLUSH/IDLE; ex_valid mispredict during REDIRECT/FLUSH -> ignored, count +1 only.
REQ-035 ex_pc=0xFFFFFFFC, predicted taken, actually not taken -> redirect_pc=0x00000000.
REQ-036 RESET pulsed mid-FLUSH -> flush=0 and count=0 asynchronously; BHT back to 01; preload count to all-ones via repeated mispredicts (CNT_W=4) -> stays 0xF.

Source files
------------

// File: rtl/branch_ctrl_unit.sv
// Branch control: 2-bit bimodal predictor (BHT), mispredict redirect/flush
// sequencer and a saturating mispredict counter.
module branch_ctrl_unit #(
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_branch_out,
  input  logic [31:0]      ex_target,
  input  logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_bht [BHT_ENTRIES];
  logic [31:0]        r_redirect_pc;
  logic [CNT_W-1:0]   r_cnt;

  logic [IDX_W-1:0]   w_if_idx;
  logic [IDX_W-1:0]   w_ex_idx;
  logic               w_resolve;
  logic               w_mispredict;
  logic [31:0]        w_ex_pc_plus4;
  logic               w_unused_pc_bits;

  assign w_if_idx         = if_pc[IDX_W+1:2];
  assign w_ex_idx         = ex_pc[IDX_W+1:2];
  assign w_unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};
  assign w_ex_pc_plus4    = ex_pc + 32'd4;

  // Wrong-path branches arriving while a redirect is in flight never resolve.
  assign w_resolve    = ex_valid && !stall && (r_state == S_IDLE);
  assign w_mispredict = w_resolve && (ex_branch_out != ex_pred_taken);

  // Reads the registered counter, so a same-cycle update is not visible yet.
  assign pred_taken = r_bht[w_if_idx][1];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_resolve) begin
      if (ex_branch_out) begin
        if (r_bht[w_ex_idx] != 2'b11) r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
      end else begin
        if (r_bht[w_ex_idx] != 2'b00) r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_redirect_pc <= 32'd0;
      r_cnt         <= '0;
    end else if (w_mispredict) begin
      r_redirect_pc <= ex_branch_out ? ex_target : w_ex_pc_plus4;
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!stall) begin
      case (r_state)
        S_IDLE:     if (w_mispredict) w_state_nxt = S_REDIRECT;
        S_REDIRECT: w_state_nxt = S_FLUSH;
        S_FLUSH:    w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    redirect = 1'b0;
    flush    = 1'b0;
    case (r_state)
      S_REDIRECT: begin
        redirect = 1'b1;
        flush    = 1'b1;
      end
      S_FLUSH:    flush = 1'b1;
      default:    ;
    endcase
  end

  assign redirect_pc      = r_redirect_pc;
  assign mispredict_count = r_cnt;

endmodule
